// File: rtl/ir_nec_pkg.sv
// NEC IR protocol definitions shared by the transmitter and receiver.
package ir_nec_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    GAP
  } nec_state_e;

  localparam int unsigned LEAD_MARK_UNITS  = 16;
  localparam int unsigned LEAD_SPACE_UNITS = 8;
  localparam int unsigned BIT_MARK_UNITS   = 1;
  localparam int unsigned ZERO_SPACE_UNITS = 1;
  localparam int unsigned ONE_SPACE_UNITS  = 3;
  localparam int unsigned STOP_MARK_UNITS  = 1;
  localparam int unsigned NEC_BITS         = 32;

  // Remote key codes, layout {~cmd, cmd, addr_hi, addr_lo}.
  localparam logic [31:0] KEY_O = 32'hED126B86;

  // Mark states pull the baseband line low.
  function automatic logic is_mark(nec_state_e s);
    return (s == LEAD_MARK) || (s == BIT_MARK) || (s == STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_transmit_if.sv
// Request/status bundle between a frame source and the NEC transmitter.
interface ir_transmit_if;
  logic        iSTART;
  logic [31:0] iDATA;
  logic        oBUSY;
  logic        oDONE;
  logic        oIRDA;
  logic        oIR_LED;

  modport master (
    output iSTART, iDATA,
    input  oBUSY, oDONE, oIRDA, oIR_LED
  );

  modport slave (
    input  iSTART, iDATA,
    output oBUSY, oDONE, oIRDA, oIR_LED
  );
endinterface

// File: rtl/ir_carrier_gen.sv
// 38 kHz carrier for the IR LED: high for the first CARRIER_DIV/3 clocks of each period.
// The phase restarts whenever iEN rises, so every mark opens with a high half-cycle.
module ir_carrier_gen #(
  parameter int unsigned CARRIER_DIV = 1316
) (
  input  logic iCLK,
  input  logic iRST_n,
  input  logic iEN,
  output logic oCARRIER
);

  localparam int unsigned CntW       = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;
  localparam int unsigned HighCycles = CARRIER_DIV / 3;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            en_q;
  logic            car_q;

  // Period counter value for the upcoming cycle; zero on the first enabled cycle.
  always_comb begin
    cnt_d = '0;
    if (iEN && en_q) begin
      cnt_d = (cnt_q == CntW'(CARRIER_DIV - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter, enable history and registered carrier output.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      cnt_q <= '0;
      en_q  <= 1'b0;
      car_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= iEN;
      car_q <= iEN && (cnt_d < CntW'(HighCycles));
    end
  end

  assign oCARRIER = car_q;

endmodule

// File: rtl/ir_transmit.sv
// NEC infrared transmitter: leader, 32 pulse-distance bits LSB first, stop mark, then a
// fixed idle gap before oDONE. Define IR_CARRIER_EN to modulate oIR_LED with a 38 kHz
// carrier during marks; otherwise oIR_LED is the inverted baseband envelope.
module ir_transmit
  import ir_nec_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 28125,
  parameter int unsigned GAP_UNITS   = 72,
  parameter int unsigned CARRIER_DIV = 1316
) (
  input  logic         iCLK,
  input  logic         iRST_n,
  ir_transmit_if.slave bus
);

  localparam int unsigned CycW    = $clog2(UNIT_CYCLES);
  localparam int unsigned UnitMax = (GAP_UNITS > LEAD_MARK_UNITS) ? GAP_UNITS : LEAD_MARK_UNITS;
  localparam int unsigned UnitW   = $clog2(UnitMax);

  localparam logic [CycW-1:0] CycLast = CycW'(UNIT_CYCLES - 1);

  nec_state_e       state_q, state_d;
  logic [CycW-1:0]  cyc_q, cyc_d;
  logic [UnitW-1:0] unit_q, unit_d;
  logic [5:0]       bit_q, bit_d;
  logic [31:0]      shift_q, shift_d;
  logic             irda_q, busy_q, done_q;

  int unsigned      dur;
  logic [UnitW-1:0] dur_m1;
  logic             tick, unit_last, state_end;

  // Length of the current state in units; a bit space depends on the bit being sent.
  always_comb begin
    dur = 1;
    case (state_q)
      LEAD_MARK:  dur = LEAD_MARK_UNITS;
      LEAD_SPACE: dur = LEAD_SPACE_UNITS;
      BIT_MARK:   dur = BIT_MARK_UNITS;
      BIT_SPACE:  dur = shift_q[0] ? ONE_SPACE_UNITS : ZERO_SPACE_UNITS;
      STOP_MARK:  dur = STOP_MARK_UNITS;
      GAP:        dur = GAP_UNITS;
      default:    dur = 1;
    endcase
    dur_m1 = UnitW'(dur - 1);
  end

  // Next-state logic: unit timing, bit sequencing and the start handshake.
  always_comb begin
    state_d   = state_q;
    cyc_d     = '0;
    unit_d    = '0;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tick      = (cyc_q == CycLast);
    unit_last = (unit_q == dur_m1);
    state_end = tick && unit_last;

    if (state_q != IDLE) begin
      cyc_d  = tick ? '0 : cyc_q + 1'b1;
      unit_d = unit_q;
      if (tick) begin
        unit_d = unit_last ? '0 : unit_q + 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.iSTART) begin
          shift_d = bus.iDATA;
          bit_d   = '0;
          state_d = LEAD_MARK;
        end
      end
      LEAD_MARK:  if (state_end) state_d = LEAD_SPACE;
      LEAD_SPACE: if (state_end) state_d = BIT_MARK;
      BIT_MARK:   if (state_end) state_d = BIT_SPACE;
      BIT_SPACE: begin
        if (state_end) begin
          shift_d = {1'b0, shift_q[31:1]};
          bit_d   = bit_q + 6'd1;
          state_d = (bit_q == 6'(NEC_BITS - 1)) ? STOP_MARK : BIT_MARK;
        end
      end
      STOP_MARK:  if (state_end) state_d = GAP;
      GAP:        if (state_end) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs; outputs mirror the state being entered.
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      unit_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      irda_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      unit_q  <= unit_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      irda_q  <= !is_mark(state_d);
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_q == GAP) && (state_d == IDLE);
    end
  end

  assign bus.oIRDA = irda_q;
  assign bus.oBUSY = busy_q;
  assign bus.oDONE = done_q;

`ifdef IR_CARRIER_EN
  logic carrier;

  ir_carrier_gen #(
    .CARRIER_DIV(CARRIER_DIV)
  ) u_carrier (
    .iCLK    (iCLK),
    .iRST_n  (iRST_n),
    .iEN     (is_mark(state_d)),
    .oCARRIER(carrier)
  );

  assign bus.oIR_LED = carrier;
`else
  assign bus.oIR_LED = ~irda_q;
`endif

endmodule

// File: tb/tb_ir_transmit.sv
// Directed bench for ir_transmit with a short time unit (4 clocks) and the default gap.
module tb_ir_transmit;

  localparam int unsigned UnitCycles = 4;
  localparam int unsigned GapUnits   = 72;
  localparam int          GapCycles  = GapUnits * UnitCycles;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  ir_transmit_if bus ();

  ir_transmit #(
    .UNIT_CYCLES(UnitCycles),
    .GAP_UNITS  (GapUnits),
    .CARRIER_DIV(1316)
  ) dut (
    .iCLK  (clk),
    .iRST_n(rst_n),
    .bus   (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge where iSTART was raised. Records oIRDA runs until oDONE, then
  // checks the frame against the NEC timing model for 'data'. With hold set, iSTART stays
  // high throughout and next_data is presented in the oDONE cycle for a back-to-back frame.
  task automatic run_frame(input logic [31:0] data, input bit hold,
                           input logic [31:0] next_data, input string tag);
    int   run_len[$];
    bit   run_lvl[$];
    int   done_t    = -1;
    int   busy_err  = 0;
    int   led_err   = 0;
    int   bad_space = 0;
    int   bad_mark  = 0;
    int   len       = 0;
    int   frame_len = 0;
    bit   cur;
    logic [31:0] word = '0;
    int   exp_frame;

    @(negedge clk);
    if (!hold) bus.iSTART = 1'b0;
    bus.iDATA = ~data;  // must not affect the frame already accepted
    cur = bus.oIRDA;
    for (int t = 0; t < 3000; t++) begin
      if (t > 0) @(negedge clk);
      if (bus.oDONE === 1'b1) begin
        done_t = t;
        break;
      end
      if (bus.oBUSY !== 1'b1) busy_err++;
`ifdef IR_CARRIER_EN
      if (t == 0 && bus.oIR_LED !== 1'b1) led_err++;
      if (bus.oIRDA === 1'b1 && bus.oIR_LED !== 1'b0) led_err++;
`else
      if (bus.oIR_LED !== ~bus.oIRDA) led_err++;
`endif
      if (bus.oIRDA !== cur) begin
        run_lvl.push_back(cur);
        run_len.push_back(len);
        cur = bus.oIRDA;
        len = 0;
      end
      len++;
    end
    run_lvl.push_back(cur);
    run_len.push_back(len);

    check_eq({tag, " done seen"}, 32'(done_t >= 0), 32'd1);
    check_eq({tag, " busy during frame"}, busy_err, 0);
    check_eq({tag, " led envelope"}, led_err, 0);
    check_eq({tag, " busy low at done"}, bus.oBUSY, 1'b0);
    check_eq({tag, " irda idle at done"}, bus.oIRDA, 1'b1);
    check_eq({tag, " first cycle is mark"}, run_lvl[0], 1'b0);
    check_eq({tag, " run count"}, run_len.size(), 68);
    if (run_len.size() == 68) begin
      check_eq({tag, " lead mark"}, run_len[0], 16 * UnitCycles);
      check_eq({tag, " lead space"}, run_len[1], 8 * UnitCycles);
      check_eq({tag, " bit0 space"}, run_len[3], data[0] ? 3 * UnitCycles : UnitCycles);
      for (int b = 0; b < 32; b++) begin
        if (run_len[2 + 2 * b] != UnitCycles) bad_mark++;
        if (run_len[3 + 2 * b] == 3 * UnitCycles) word[b] = 1'b1;
        else if (run_len[3 + 2 * b] != UnitCycles) bad_space++;
      end
      check_eq({tag, " bit marks"}, bad_mark, 0);
      check_eq({tag, " bit spaces"}, bad_space, 0);
      check_eq({tag, " decoded word"}, word, data);
      check_eq({tag, " stop mark"}, run_len[66], UnitCycles);
      check_eq({tag, " gap"}, run_len[67], GapCycles);
      for (int i = 0; i < 67; i++) frame_len += run_len[i];
      exp_frame = (89 + 2 * $countones(data)) * UnitCycles;
      check_eq({tag, " frame length"}, frame_len, exp_frame);
      check_eq({tag, " done time"}, done_t, exp_frame + GapCycles);
    end
    if (hold) bus.iDATA = next_data;
  endtask

  initial begin
    int idle_err = 0;
    int done_cnt = 0;

    bus.iSTART = 1'b0;
    bus.iDATA  = '0;

    // Asynchronous reset with no clock edge involved.
    #1 rst_n = 1'b0;
    #1;
    check_eq("reset irda", bus.oIRDA, 1'b1);
    check_eq("reset led", bus.oIR_LED, 1'b0);
    check_eq("reset busy", bus.oBUSY, 1'b0);
    check_eq("reset done", bus.oDONE, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle line stays quiet.
    repeat (100) begin
      @(negedge clk);
      if (bus.oIRDA !== 1'b1 || bus.oIR_LED !== 1'b0 || bus.oBUSY !== 1'b0) idle_err++;
      if (bus.oDONE !== 1'b0) done_cnt++;
    end
    check_eq("idle outputs", idle_err, 0);
    check_eq("idle done pulses", done_cnt, 0);

    // Single frames with distinct bit patterns.
    @(negedge clk);
    bus.iDATA  = 32'hED126B86;
    bus.iSTART = 1'b1;
    run_frame(32'hED126B86, 1'b0, 32'h0, "keyo");

    @(negedge clk);
    bus.iDATA  = 32'h0000_0000;
    bus.iSTART = 1'b1;
    run_frame(32'h0000_0000, 1'b0, 32'h0, "zeros");

    @(negedge clk);
    bus.iDATA  = 32'hFFFF_FFFF;
    bus.iSTART = 1'b1;
    run_frame(32'hFFFF_FFFF, 1'b0, 32'h0, "ones");

    // iSTART held high: the second frame starts in the oDONE cycle's following edge,
    // so its first sampled cycle must already be the leader mark.
    @(negedge clk);
    bus.iDATA  = 32'h1234_5678;
    bus.iSTART = 1'b1;
    run_frame(32'h1234_5678, 1'b1, 32'hED126B86, "held1");
    run_frame(32'hED126B86, 1'b0, 32'h0, "held2");

    // Reset during bit 10 of an all-zero frame (bit 10 mark spans cycles 176..179).
    @(negedge clk);
    bus.iDATA  = 32'h0;
    bus.iSTART = 1'b1;
    @(negedge clk);
    bus.iSTART = 1'b0;
    repeat (178) @(negedge clk);
    check_eq("bit10 is mark", bus.oIRDA, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midframe reset irda", bus.oIRDA, 1'b1);
    check_eq("midframe reset led", bus.oIR_LED, 1'b0);
    check_eq("midframe reset busy", bus.oBUSY, 1'b0);
    check_eq("midframe reset done", bus.oDONE, 1'b0);
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.oDONE !== 1'b0 || bus.oBUSY !== 1'b0) done_cnt++;
    end
    check_eq("post reset quiet", done_cnt, 0);

    @(negedge clk);
    bus.iDATA  = 32'hED126B86;
    bus.iSTART = 1'b1;
    run_frame(32'hED126B86, 1'b0, 32'h0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ir_transmit.md
Name: ir_transmit

Overview:
NEC-format infrared transmitter, the sending end of the IR link whose receiver decodes 32-bit frames into oDATA/oDATA_READY.
- Accepts a 32-bit code word with a start/busy/done handshake.
- Serialises the word as an NEC frame: leader, 32 pulse-distance bits LSB first, stop mark, then an enforced inter-frame gap.
- Drives an idle-high baseband line (oIRDA) for wired loopback into the receiver's iIRDA, plus an LED drive (oIR_LED).

Parameters:
UNIT_CYCLES, 28125, clocks per NEC time unit (562.5 us at 50 MHz); must be >= 2.
GAP_UNITS, 72, idle units enforced after the stop mark before oDONE/next frame; must be >= 1.
CARRIER_DIV, 1316, clocks per 38 kHz carrier period (used only with IR_CARRIER_EN).

Ports:
iCLK  in  1  system clock (50 MHz nominal)
iRST_n  in  1  reset, asynchronous, active-low
iSTART  in  1  request to send iDATA; sampled on rising iCLK
iDATA  in  32  code word; bit 0 transmitted first (layout {~cmd, cmd, addr_hi, addr_lo}, same as receiver oDATA)
oBUSY  out  1  high while a frame or gap is in progress
oDONE  out  1  one-cycle pulse when the gap completes
oIRDA  out  1  baseband line: 0 during mark, 1 during space/idle
oIR_LED  out  1  LED drive: 1 during mark (see Optional Feature), 0 otherwise

Behaviour:
- Reset (async, iRST_n=0): state IDLE, all counters 0, oBUSY=0, oDONE=0, oIRDA=1, oIR_LED=0. Takes effect immediately, including mid-frame; the partial frame is abandoned with no oDONE.
- Handshake:
  - iSTART=1 in IDLE at a rising edge: iDATA is latched into a shift register.
  - The next cycle enters LEAD_MARK with oBUSY=1 and oIRDA=0 (1-cycle latency).
  - iSTART while oBUSY=1 is ignored (no queueing). Changes to iDATA after the accept have no effect.
- States and durations (1 unit = UNIT_CYCLES clocks, exact):
  - LEAD_MARK 16 units (mark) -> LEAD_SPACE 8 units (space).
  - -> BIT_MARK 1 unit (mark) -> BIT_SPACE: 1 unit if the current bit = 0, 3 units if it = 1.
  - After BIT_SPACE, the shift register shifts right and the bit index increments. If index < 32, go to BIT_MARK; after bit 31, go to STOP_MARK.
  - STOP_MARK 1 unit (mark) -> GAP for GAP_UNITS units (space).
  - At the final GAP cycle: next state IDLE. oDONE=1 and oBUSY=0 in the first IDLE cycle.
- iSTART=1 in that same IDLE cycle is accepted normally, giving back-to-back frames separated by exactly the gap.
- Frame length, leader through stop mark: 89 + 2*popcount(iDATA) units. All-zero word: 89 units; all-ones word: 153 units.
- Outputs are registered (glitch-free); oIRDA and oIR_LED change on the same edge.
- Counters: cycle counter 0..UNIT_CYCLES-1 with wrap producing a unit tick; unit counter sized for max(16, GAP_UNITS); bit index 0..31 (6 bits).

Optional Feature:
Macro IR_CARRIER_EN.
- Defined: during mark, oIR_LED is a 38 kHz square wave: high for the first CARRIER_DIV/3 clocks (integer division) of each CARRIER_DIV period.
  - The carrier counter resets to 0 at the start of each mark, so every mark begins with oIR_LED=1.
  - oIR_LED=0 during space, idle, and reset.
- Undefined: oIR_LED = ~oIRDA (plain envelope); the carrier counter is not synthesised.
- oIRDA is unaffected in both cases.

Decomposition:
- Package ir_nec_pkg holds:
  - state enum (IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, GAP);
  - constants LEAD_MARK_UNITS=16, LEAD_SPACE_UNITS=8, BIT_MARK_UNITS=1, ZERO_SPACE_UNITS=1, ONE_SPACE_UNITS=3, STOP_MARK_UNITS=1, NEC_BITS=32;
  - shared key codes, e.g. KEY_O=32'hED126B86, also usable by the receiver side.
- Sub-module ir_carrier_gen (iCLK, iRST_n, iEN, oCARRIER; parameter CARRIER_DIV) is instantiated only under IR_CARRIER_EN.

Test Plan:
- Reset then idle 100 cycles -> oIRDA=1, oIR_LED=0, oBUSY=0, oDONE never pulses.
- UNIT_CYCLES=4, GAP_UNITS=72, iDATA=32'hED126B86 (popcount 16), one-cycle iSTART:
  - oIRDA low exactly 64 cycles from 1 cycle after the accept, then high 32 cycles;
  - first bit (0) = mark 4 cycles, space 4 cycles;
  - frame 121 units = 484 cycles; oDONE 772 cycles after LEAD_MARK entry.
- UNIT_CYCLES=4, iDATA=0 then iDATA=32'hFFFFFFFF -> frame lengths 356 and 612 cycles; each bit-1 space is 12 cycles.
- iSTART held high continuously -> frames back-to-back with exactly 288-cycle gaps; iSTART pulses mid-frame do not restart the frame or change the transmitted bits.
- iRST_n asserted during bit 10 -> outputs return to idle values asynchronously, with no oDONE. After release, a new iSTART sends a complete, correct frame.
- Loopback with UNIT_CYCLES=28125: oIRDA drives the receiver's iIRDA with iDATA=32'hED126B86 -> receiver pulses oDATA_READY with oDATA=32'hED126B86. With IR_CARRIER_EN, oIR_LED toggles with a 1316-cycle period during marks only.
